// File: rtl/glitch_pkg.sv
// -----------------------------------------------------------------------------
// glitch_pkg
// Shared definitions for the glitch command controller:
//   - UART command opcodes (prefix byte and command bytes)
//   - controller FSM state enumeration
//   - configuration target enumeration and the opcode -> target decoder
// -----------------------------------------------------------------------------
package glitch_pkg;

    // Command opcodes
    localparam logic [7:0] CMD_PREFIX    = 8'h00;
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_BOARD_RST = 8'hFE;
    localparam logic [7:0] CMD_WIDTH     = 8'h10;
    localparam logic [7:0] CMD_PCOUNT    = 8'h11;
    localparam logic [7:0] CMD_DELAY0    = 8'h20;
    localparam logic [7:0] CMD_DELAY1    = 8'h21;
    localparam logic [7:0] CMD_DELAY2    = 8'h22;
    localparam logic [7:0] CMD_DELAY3    = 8'h23;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ARG  = 2'd2,
        PASS = 2'd3
    } state_t;

    // Configuration register selected by a write opcode
    typedef enum logic [2:0] {
        TGT_WIDTH  = 3'd0,
        TGT_PCOUNT = 3'd1,
        TGT_DELAY0 = 3'd2,
        TGT_DELAY1 = 3'd3,
        TGT_DELAY2 = 3'd4,
        TGT_DELAY3 = 3'd5
    } tgt_t;

    typedef struct packed {
        logic valid;   // opcode is a register-write command
        tgt_t tgt;     // register it writes
    } tgt_dec_t;

    // Maps a write opcode to its target register; valid=0 for anything else.
    function automatic tgt_dec_t decode_target(input logic [7:0] op);
        tgt_dec_t d;
        d.valid = 1'b1;
        d.tgt   = TGT_WIDTH;
        case (op)
            CMD_WIDTH:  d.tgt = TGT_WIDTH;
            CMD_PCOUNT: d.tgt = TGT_PCOUNT;
            CMD_DELAY0: d.tgt = TGT_DELAY0;
            CMD_DELAY1: d.tgt = TGT_DELAY1;
            CMD_DELAY2: d.tgt = TGT_DELAY2;
            CMD_DELAY3: d.tgt = TGT_DELAY3;
            default:    d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
// Turns a one-cycle start strobe into a pulse exactly CYCLES clocks long.
// A start while the pulse is running restarts the count; clear ends it at once.
//
// Parameters:
//   CYCLES  pulse length in clk cycles
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset
//   start  one-cycle strobe, (re)loads the count
//   clear  one-cycle strobe, terminates the pulse
//   pulse  high while the count is nonzero
// -----------------------------------------------------------------------------
module pulse_stretch #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic pulse
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= CW'(CYCLES);
        end else if (clear) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign pulse = (count != '0);

endmodule

// File: rtl/glitch_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// glitch_cmd_ctrl
// UART byte command decoder for a glitch engine. A 0x00 prefix introduces a
// command (reset, board reset + arm, or a register write followed by one
// argument byte). A nonzero byte in IDLE opens a passthrough window of that
// many bytes, forwarded through a one-entry holding register.
//
// Build option: define GLITCH_CMD_PASSTHROUGH_EN to implement the passthrough
// path. Without it, nonzero bytes in IDLE are rejected with err and the pt_*
// outputs are tied off.
//
// Parameters:
//   RST_CYCLES      board_rst pulse length in clk cycles
//   TIMEOUT_CYCLES  idle cycles in CMD/ARG before the command is abandoned
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   rx_data       received UART byte
//   rx_valid      one-cycle strobe qualifying rx_data
//   glitch_busy   glitch engine running; blocks arm and register writes
//   width         glitch pulse width
//   pulse_count   glitch pulse count
//   delay         delay before glitch, written one byte at a time
//   glitch_arm    one-cycle arm strobe
//   board_rst     target reset, RST_CYCLES long
//   sys_rst       one-cycle soft reset to the rest of the design
//   pt_data       passthrough byte
//   pt_valid      pt_data valid, held until pt_ready
//   pt_ready      passthrough consumer accepts the byte
//   err           one-cycle strobe for rejected, unknown or dropped bytes
// -----------------------------------------------------------------------------
module glitch_cmd_ctrl
    import glitch_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        glitch_busy,
    output logic [7:0]  width,
    output logic [7:0]  pulse_count,
    output logic [31:0] delay,
    output logic        glitch_arm,
    output logic        board_rst,
    output logic        sys_rst,
    output logic [7:0]  pt_data,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_next;
    tgt_t          tgt;
    tgt_dec_t      cmd_dec;
    logic [TW-1:0] idle_cnt;
    logic          in_cmd;
    logic          timeout;

    // Decisions made by the FSM for the current cycle
    logic arm_set, sys_set, err_set;
    logic tgt_load, cfg_write, cfg_clear;
    logic bst_start, bst_clear;

`ifdef GLITCH_CMD_PASSTHROUGH_EN
    logic [7:0] countdown;
    logic [7:0] hold_data;
    logic       hold_valid;
    logic       cnt_load, pass_byte, pt_load;
`endif

    assign cmd_dec = decode_target(rx_data);
    assign in_cmd  = (state == CMD) || (state == ARG);
    // Abandon a half-received command after TIMEOUT_CYCLES silent cycles.
    assign timeout = in_cmd && !rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        arm_set    = 1'b0;
        sys_set    = 1'b0;
        err_set    = 1'b0;
        tgt_load   = 1'b0;
        cfg_write  = 1'b0;
        cfg_clear  = 1'b0;
        bst_start  = 1'b0;
        bst_clear  = 1'b0;
`ifdef GLITCH_CMD_PASSTHROUGH_EN
        cnt_load   = 1'b0;
        pass_byte  = 1'b0;
        pt_load    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_PREFIX) begin
                        state_next = CMD;
                    end else begin
`ifdef GLITCH_CMD_PASSTHROUGH_EN
                        cnt_load   = 1'b1;
                        state_next = PASS;
`else
                        err_set    = 1'b1;
`endif
                    end
                end
            end
            CMD: begin
                if (rx_valid) begin
                    state_next = IDLE;
                    if (rx_data == CMD_RESET) begin
                        sys_set   = 1'b1;
                        cfg_clear = 1'b1;
                        bst_clear = 1'b1;
                    end else if (rx_data == CMD_BOARD_RST) begin
                        if (glitch_busy) begin
                            err_set = 1'b1;
                        end else begin
                            arm_set   = 1'b1;
                            bst_start = 1'b1;
                        end
                    end else if (cmd_dec.valid) begin
                        tgt_load   = 1'b1;
                        state_next = ARG;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            ARG: begin
                if (rx_valid) begin
                    state_next = IDLE;
                    if (glitch_busy) begin
                        err_set = 1'b1;
                    end else begin
                        cfg_write = 1'b1;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            PASS: begin
`ifdef GLITCH_CMD_PASSTHROUGH_EN
                if (rx_valid) begin
                    pass_byte = 1'b1;
                    // Full and not draining this cycle: the byte is lost.
                    if (hold_valid && !pt_ready) begin
                        err_set = 1'b1;
                    end else begin
                        pt_load = 1'b1;
                    end
                    if (countdown == 8'd1) begin
                        state_next = IDLE;
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Consecutive silent cycles while a command is open
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (in_cmd && !rx_valid && !timeout) begin
            idle_cnt <= idle_cnt + TW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end

    // Latched write target and configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt         <= TGT_WIDTH;
            width       <= 8'h00;
            pulse_count <= 8'h00;
            delay       <= 32'h0000_0000;
        end else begin
            if (tgt_load) begin
                tgt <= cmd_dec.tgt;
            end
            if (cfg_clear) begin
                width       <= 8'h00;
                pulse_count <= 8'h00;
                delay       <= 32'h0000_0000;
            end else if (cfg_write) begin
                case (tgt)
                    TGT_WIDTH:  width         <= rx_data;
                    TGT_PCOUNT: pulse_count   <= rx_data;
                    TGT_DELAY0: delay[7:0]    <= rx_data;
                    TGT_DELAY1: delay[15:8]   <= rx_data;
                    TGT_DELAY2: delay[23:16]  <= rx_data;
                    TGT_DELAY3: delay[31:24]  <= rx_data;
                    default:    width         <= width;
                endcase
            end
        end
    end

    // One-cycle strobes, registered so they are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_arm <= 1'b0;
            sys_rst    <= 1'b0;
            err        <= 1'b0;
        end else begin
            glitch_arm <= arm_set;
            sys_rst    <= sys_set;
            err        <= err_set;
        end
    end

    pulse_stretch #(
        .CYCLES (RST_CYCLES)
    ) u_board_rst (
        .clk   (clk),
        .rst   (rst),
        .start (bst_start),
        .clear (bst_clear),
        .pulse (board_rst)
    );

`ifdef GLITCH_CMD_PASSTHROUGH_EN
    // Passthrough length countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countdown <= 8'h00;
        end else if (cnt_load) begin
            countdown <= rx_data;
        end else if (pass_byte) begin
            countdown <= countdown - 8'd1;
        end
    end

    // One-entry holding register; a load may coincide with a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= 8'h00;
            hold_valid <= 1'b0;
        end else if (pt_load) begin
            hold_data  <= rx_data;
            hold_valid <= 1'b1;
        end else if (hold_valid && pt_ready) begin
            hold_valid <= 1'b0;
        end
    end

    assign pt_data  = hold_data;
    assign pt_valid = hold_valid;
`else
    logic unused_pt_ready;
    assign unused_pt_ready = pt_ready;
    assign pt_data         = 8'h00;
    assign pt_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_glitch_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_glitch_cmd_ctrl
// Self-checking bench for glitch_cmd_ctrl. A byte-level reference model
// (mode number, config byte array, holding queue, remaining-cycle counters)
// predicts every output each cycle; directed sequences additionally check
// fixed expected results. Works with or without GLITCH_CMD_PASSTHROUGH_EN.
// -----------------------------------------------------------------------------
module tb_glitch_cmd_ctrl;

    localparam int RST_CYC = 16;
    localparam int TMO     = 60;

`ifdef GLITCH_CMD_PASSTHROUGH_EN
    localparam bit PT_EN = 1'b1;
`else
    localparam bit PT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        glitch_busy = 1'b0;
    logic        pt_ready = 1'b1;
    logic [7:0]  width, pulse_count, pt_data;
    logic [31:0] delay;
    logic        glitch_arm, board_rst, sys_rst, pt_valid, err;

    always #5 clk = ~clk;

    glitch_cmd_ctrl #(
        .RST_CYCLES     (RST_CYC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .glitch_busy (glitch_busy),
        .width       (width),
        .pulse_count (pulse_count),
        .delay       (delay),
        .glitch_arm  (glitch_arm),
        .board_rst   (board_rst),
        .sys_rst     (sys_rst),
        .pt_data     (pt_data),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .err         (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_OP = 1, M_ARG = 2, M_PASS = 3;

    int         m_mode, m_idle, m_remain, m_tgt, m_brst;
    logic [7:0] m_cfg [6];          // width, pulse_count, delay bytes 0..3
    logic [7:0] m_q [$];            // holding register contents (0 or 1 byte)
    bit         e_arm, e_sys, e_err;

    // Observed event counters for directed checks
    int         n_arm, n_brst, n_sys, n_err;
    logic [7:0] obs_pt [$];

    function automatic int opcode_slot(input logic [7:0] d);
        if (d == 8'h10) return 0;
        if (d == 8'h11) return 1;
        if (d >= 8'h20 && d <= 8'h23) return 2 + int'(d - 8'h20);
        return -1;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_idle = 0; m_remain = 0; m_tgt = 0; m_brst = 0;
        for (int i = 0; i < 6; i++) m_cfg[i] = 8'h00;
        m_q.delete();
        e_arm = 0; e_sys = 0; e_err = 0;
    endfunction

    function automatic void model_edge(input bit v, input logic [7:0] d,
                                       input bit busy, input bit ready);
        bit stuck;
        int slot;
        stuck = (m_q.size() != 0) && !ready;
        e_arm = 0; e_sys = 0; e_err = 0;
        if (m_brst > 0) m_brst--;
        if (m_q.size() != 0 && ready) void'(m_q.pop_front());
        case (m_mode)
            M_IDLE: if (v) begin
                if (d == 8'h00) begin
                    m_mode = M_OP; m_idle = 0;
                end else if (PT_EN) begin
                    m_mode = M_PASS; m_remain = int'(d);
                end else begin
                    e_err = 1;
                end
            end
            M_OP: if (v) begin
                m_mode = M_IDLE; m_idle = 0;
                if (d == 8'hFF) begin
                    e_sys = 1; m_brst = 0;
                    for (int i = 0; i < 6; i++) m_cfg[i] = 8'h00;
                end else if (d == 8'hFE) begin
                    if (busy) e_err = 1;
                    else begin e_arm = 1; m_brst = RST_CYC; end
                end else begin
                    slot = opcode_slot(d);
                    if (slot >= 0) begin m_tgt = slot; m_mode = M_ARG; end
                    else e_err = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin m_mode = M_IDLE; m_idle = 0; end
            end
            M_ARG: if (v) begin
                m_mode = M_IDLE; m_idle = 0;
                if (busy) e_err = 1;
                else m_cfg[m_tgt] = d;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin m_mode = M_IDLE; m_idle = 0; end
            end
            default: if (v) begin
                if (stuck) e_err = 1;
                else m_q.push_back(d);
                m_remain--;
                if (m_remain == 0) m_mode = M_IDLE;
            end
        endcase
    endfunction

    task automatic compare_all();
        check("width", width, m_cfg[0]);
        check("pcount", pulse_count, m_cfg[1]);
        check("delay", delay, {m_cfg[5], m_cfg[4], m_cfg[3], m_cfg[2]});
        check("arm", glitch_arm, e_arm);
        check("sysrst", sys_rst, e_sys);
        check("err", err, e_err);
        check("brst", board_rst, m_brst > 0);
        check("ptv", pt_valid, m_q.size() != 0);
`ifdef GLITCH_CMD_PASSTHROUGH_EN
        if (m_q.size() != 0) check("ptd", pt_data, m_q[0]);
`else
        check("ptd", pt_data, 8'h00);
`endif
        if (glitch_arm) n_arm++;
        if (board_rst) n_brst++;
        if (sys_rst) n_sys++;
        if (err) n_err++;
        if (pt_valid && pt_ready) obs_pt.push_back(pt_data);
    endtask

    // One clock: inputs are applied #1 after the previous edge, outputs
    // are checked #1 after this edge.
    task automatic step(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_edge(v, d, glitch_busy, pt_ready);
        #1;
        compare_all();
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic clear_counts();
        n_arm = 0; n_brst = 0; n_sys = 0; n_err = 0;
        obs_pt.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_width", width, 8'h00);
            check("rst_pcount", pulse_count, 8'h00);
            check("rst_delay", delay, 32'h0);
            check("rst_arm", glitch_arm, 1'b0);
            check("rst_brst", board_rst, 1'b0);
            check("rst_sys", sys_rst, 1'b0);
            check("rst_ptv", pt_valid, 1'b0);
            check("rst_err", err, 1'b0);
        end
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pick [12];
        pick = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h20,
                 8'h21, 8'h22, 8'h23, 8'hFE, 8'hFF, 8'h03};

        model_reset();
        clear_counts();
        do_reset();

        // Register write to width
        clear_counts();
        send(8'h00); send(8'h10); send(8'h22); idle(1);
        check("w22", width, 8'h22);
        check("w22_err", n_err, 0);

        // Delay bytes assembled little-endian
        send(8'h00); send(8'h20); send(8'h32);
        send(8'h00); send(8'h23); send(8'h01); idle(1);
        check("delay_le", delay, 32'h0100_0032);

        // Write blocked while the engine is busy
        send(8'h00); send(8'h11); send(8'h44); idle(1);
        clear_counts();
        glitch_busy = 1'b1;
        send(8'h00); send(8'h11); send(8'h07);
        glitch_busy = 1'b0;
        idle(1);
        check("busy_pcount", pulse_count, 8'h44);
        check("busy_err", n_err, 1);

        // Arm is refused while busy
        clear_counts();
        glitch_busy = 1'b1;
        send(8'h00); send(8'hFE);
        glitch_busy = 1'b0;
        idle(2);
        check("busy_fe_arm", n_arm, 0);
        check("busy_fe_brst", n_brst, 0);
        check("busy_fe_err", n_err, 1);

        // Arm + board reset exactly RST_CYC long
        clear_counts();
        send(8'h00); send(8'hFE); idle(20);
        check("fe_arm", n_arm, 1);
        check("fe_brst_len", n_brst, 16);

        // Re-arm during board reset restarts the count: 6 + 16 cycles
        clear_counts();
        send(8'h00); send(8'hFE); idle(4);
        send(8'h00); send(8'hFE); idle(20);
        check("restart_arm", n_arm, 2);
        check("restart_brst", n_brst, 22);

        // Soft reset during board reset clears it and all registers
        clear_counts();
        send(8'h00); send(8'hFE); idle(2);
        send(8'h00); send(8'hFF);
        check("ff_brst_clr", board_rst, 1'b0);
        idle(1);
        check("ff_sys", n_sys, 1);
        check("ff_width", width, 8'h00);
        check("ff_pcount", pulse_count, 8'h00);
        check("ff_delay", delay, 32'h0);

        // Command survives TMO-1 silent cycles
        send(8'h00); idle(TMO - 1); send(8'h10); send(8'h77); idle(1);
        check("tmo_edge_width", width, 8'h77);

`ifdef GLITCH_CMD_PASSTHROUGH_EN
        // Passthrough with consumer always ready
        pt_ready = 1'b1;
        clear_counts();
        send(8'h05); send(8'hFF); send(8'h55); send(8'h00); send(8'hAA); send(8'h00);
        idle(2);
        check("pt_count", obs_pt.size(), 5);
        if (obs_pt.size() == 5) begin
            check("pt_b0", obs_pt[0], 8'hFF);
            check("pt_b1", obs_pt[1], 8'h55);
            check("pt_b2", obs_pt[2], 8'h00);
            check("pt_b3", obs_pt[3], 8'hAA);
            check("pt_b4", obs_pt[4], 8'h00);
        end
        check("pt_sys", n_sys, 0);
        send(8'h00); send(8'h10); send(8'h33); idle(1);
        check("pt_then_idle", width, 8'h33);

        // Stalled consumer: second byte dropped
        pt_ready = 1'b0;
        clear_counts();
        send(8'h02); send(8'hAA); send(8'hBB); idle(1);
        check("stall_ptv", pt_valid, 1'b1);
        check("stall_ptd", pt_data, 8'hAA);
        check("stall_err", n_err, 1);
        send(8'h00); send(8'h10); send(8'h44); idle(1);
        check("stall_idle", width, 8'h44);
        pt_ready = 1'b1;
        idle(2);

        // Timed-out prefix: next byte opens a passthrough window
        clear_counts();
        send(8'h00); idle(TMO); send(8'h10); send(8'h5A); idle(1);
        check("tmo_width", width, 8'h44);
        check("tmo_pt", obs_pt.size(), 1);
        check("tmo_err", n_err, 0);
`else
        // Nonzero byte in IDLE is rejected
        clear_counts();
        send(8'h05); idle(1);
        check("nopt_err", n_err, 1);
        check("nopt_ptv", pt_valid, 1'b0);

        // Timed-out prefix: next byte is rejected, not a command
        clear_counts();
        send(8'h00); idle(TMO); send(8'h10); send(8'h5A); idle(1);
        check("tmo_width", width, 8'h77);
        check("tmo_err", n_err, 2);
`endif

        // Reset in the middle of a command discards it
        send(8'h00); send(8'h10);
        do_reset();
        send(8'h22); idle(2);
        check("midrst_width", width, 8'h00);

        // Randomized traffic against the model
        for (int it = 0; it < 3000; it++) begin
            glitch_busy = ($urandom_range(0, 7) == 0);
            pt_ready    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                idle(TMO + 2);
            end else if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b1, 8'($urandom_range(0, 255)));
                else
                    step(1'b1, pick[$urandom_range(0, 11)]);
            end else begin
                step(1'b0, 8'($urandom_range(0, 255)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
